// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the multi-channel burst pulse generator.
package pulse_gen_pkg;

  localparam int unsigned CNT_W_DEF = 32;

  localparam logic RETRIG_IGNORE  = 1'b0;
  localparam logic RETRIG_RESTART = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } chan_state_e;

endpackage

// File: rtl/pulse_gen_chan.sv
// One burst channel: trigger acceptance, config shadowing with clamps,
// and the DELAY/HIGH/LOW sequencer with registered pulse/busy/done.
module pulse_gen_chan
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned DEFAULT_WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig_edge,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             cfg_retrig,
  output logic             pulse,
  output logic             busy,
  output logic             done
);

  chan_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] sh_width;
  logic [CNT_W-1:0] sh_low;

  logic             accept_c;
  logic [CNT_W-1:0] count_m1_c;
  logic [CNT_W-1:0] low_m1_c;

  // Low phase is stored as (length-1) so a max-width pulse never overflows.
  assign accept_c   = trig_edge && (cfg_width != '0) &&
                      ((state == ST_IDLE) || (cfg_retrig == RETRIG_RESTART));
  assign count_m1_c = (cfg_count == '0) ? '0 : cfg_count - CNT_W'(1);
  assign low_m1_c   = (cfg_period > cfg_width) ? cfg_period - cfg_width - CNT_W'(1) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rem      <= '0;
      sh_width <= CNT_W'(DEFAULT_WIDTH);
      sh_low   <= '0;
      pulse    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        cnt   <= '0;
        rem   <= '0;
        pulse <= 1'b0;
        busy  <= 1'b0;
      end else if (accept_c) begin
        sh_width <= cfg_width;
        sh_low   <= low_m1_c;
        rem      <= count_m1_c;
        busy     <= 1'b1;
        if (cfg_delay == '0) begin
          state <= ST_HIGH;
          cnt   <= cfg_width - CNT_W'(1);
          pulse <= 1'b1;
        end else begin
          state <= ST_DELAY;
          cnt   <= cfg_delay - CNT_W'(1);
          pulse <= 1'b0;
        end
      end else begin
        case (state)
          ST_DELAY, ST_LOW: begin
            if (cnt == '0) begin
              state <= ST_HIGH;
              cnt   <= sh_width - CNT_W'(1);
              pulse <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_HIGH: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else if (rem != '0) begin
              state <= ST_LOW;
              rem   <= rem - CNT_W'(1);
              cnt   <= sh_low;
              pulse <= 1'b0;
            end else begin
              state <= ST_IDLE;
              pulse <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/pulse_gen_burst.sv
// Multi-channel burst pulse generator: shared trigger edge detect feeding
// NUM_CH independent channels.
module pulse_gen_burst
  import pulse_gen_pkg::*;
#(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned DEFAULT_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trigger,
  input  logic                    abort,
  input  logic [NUM_CH*CNT_W-1:0] cfg_delay,
  input  logic [NUM_CH*CNT_W-1:0] cfg_width,
  input  logic [NUM_CH*CNT_W-1:0] cfg_period,
  input  logic [NUM_CH*CNT_W-1:0] cfg_count,
  input  logic [NUM_CH-1:0]       cfg_retrig,
  output logic [NUM_CH-1:0]       pulse,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);

  logic last_trigger;
  logic trig_edge_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_trigger <= 1'b0;
    else     last_trigger <= trigger;
  end

  assign trig_edge_c = trigger & ~last_trigger;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_gen_chan #(
      .CNT_W         (CNT_W),
      .DEFAULT_WIDTH (DEFAULT_WIDTH)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .trig_edge  (trig_edge_c),
      .abort      (abort),
      .cfg_delay  (cfg_delay[i*CNT_W +: CNT_W]),
      .cfg_width  (cfg_width[i*CNT_W +: CNT_W]),
      .cfg_period (cfg_period[i*CNT_W +: CNT_W]),
      .cfg_count  (cfg_count[i*CNT_W +: CNT_W]),
      .cfg_retrig (cfg_retrig[i]),
      .pulse      (pulse[i]),
      .busy       (busy[i]),
      .done       (done[i])
    );
  end

endmodule

// File: tb/tb_pulse_gen_burst.sv
// Directed bench for pulse_gen_burst with two channels and 32-bit counters.
module tb_pulse_gen_burst;
  import pulse_gen_pkg::*;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CNT_W  = 32;

  logic                    clk;
  logic                    rst;
  logic                    trigger;
  logic                    abort;
  logic [NUM_CH*CNT_W-1:0] cfg_delay;
  logic [NUM_CH*CNT_W-1:0] cfg_width;
  logic [NUM_CH*CNT_W-1:0] cfg_period;
  logic [NUM_CH*CNT_W-1:0] cfg_count;
  logic [NUM_CH-1:0]       cfg_retrig;
  logic [NUM_CH-1:0]       pulse;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;

  int checks = 0;
  int errors = 0;

  pulse_gen_burst #(
    .NUM_CH        (NUM_CH),
    .CNT_W         (CNT_W),
    .DEFAULT_WIDTH (128)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trigger    (trigger),
    .abort      (abort),
    .cfg_delay  (cfg_delay),
    .cfg_width  (cfg_width),
    .cfg_period (cfg_period),
    .cfg_count  (cfg_count),
    .cfg_retrig (cfg_retrig),
    .pulse      (pulse),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [NUM_CH-1:0] obs, input logic [NUM_CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] ep, input logic [1:0] eb, input logic [1:0] ed);
    check({tag, ".pulse"}, pulse, ep);
    check({tag, ".busy"},  busy,  eb);
    check({tag, ".done"},  done,  ed);
  endtask

  task automatic run_expect(input string tag, input int n, input logic [1:0] ep,
                            input logic [1:0] eb, input logic [1:0] ed);
    for (int i = 0; i < n; i++) begin
      tick();
      check_all(tag, ep, eb, ed);
    end
  endtask

  task automatic set_ch(input int ch, input logic [31:0] d, input logic [31:0] w,
                        input logic [31:0] p, input logic [31:0] c);
    cfg_delay[ch*CNT_W +: CNT_W]  = d;
    cfg_width[ch*CNT_W +: CNT_W]  = w;
    cfg_period[ch*CNT_W +: CNT_W] = p;
    cfg_count[ch*CNT_W +: CNT_W]  = c;
  endtask

  initial begin
    rst        = 1'b1;
    trigger    = 1'b0;
    abort      = 1'b0;
    cfg_delay  = '0;
    cfg_width  = '0;
    cfg_period = '0;
    cfg_count  = '0;
    cfg_retrig = {RETRIG_IGNORE, RETRIG_IGNORE};
    tick();
    tick();
    check_all("reset", 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    run_expect("idle", 2, 2'b00, 2'b00, 2'b00);

    // single 128-cycle pulse on ch0; ch1 width 0 stays silent
    set_ch(0, 0, 128, 0, 1);
    set_ch(1, 0, 0, 0, 1);
    trigger = 1'b1;
    run_expect("single.high", 128, 2'b01, 2'b01, 2'b00);
    run_expect("single.done", 1, 2'b00, 2'b00, 2'b01);
    run_expect("single.after", 2, 2'b00, 2'b00, 2'b00);

    // delay 5, 3 high / 5 low, 4 pulses
    trigger = 1'b0;
    set_ch(0, 5, 3, 8, 4);
    run_expect("burst.pre", 1, 2'b00, 2'b00, 2'b00);
    trigger = 1'b1;
    run_expect("burst.delay", 5, 2'b00, 2'b01, 2'b00);
    for (int k = 0; k < 4; k++) begin
      run_expect("burst.high", 3, 2'b01, 2'b01, 2'b00);
      if (k < 3) run_expect("burst.low", 5, 2'b00, 2'b01, 2'b00);
    end
    run_expect("burst.done", 1, 2'b00, 2'b00, 2'b01);
    run_expect("burst.after", 1, 2'b00, 2'b00, 2'b00);

    // clamps: count 0 -> 1, period 2 <= width 4 -> one low cycle
    trigger = 1'b0;
    set_ch(0, 0, 4, 2, 0);
    run_expect("clamp1.pre", 1, 2'b00, 2'b00, 2'b00);
    trigger = 1'b1;
    run_expect("clamp1.high", 4, 2'b01, 2'b01, 2'b00);
    run_expect("clamp1.done", 1, 2'b00, 2'b00, 2'b01);
    trigger = 1'b0;
    set_ch(0, 0, 4, 2, 2);
    run_expect("clamp2.pre", 1, 2'b00, 2'b00, 2'b00);
    trigger = 1'b1;
    run_expect("clamp2.high0", 4, 2'b01, 2'b01, 2'b00);
    run_expect("clamp2.low", 1, 2'b00, 2'b01, 2'b00);
    run_expect("clamp2.high1", 4, 2'b01, 2'b01, 2'b00);
    run_expect("clamp2.done", 1, 2'b00, 2'b00, 2'b01);
    trigger = 1'b0;
    set_ch(0, 0, 0, 5, 1);
    run_expect("w0.pre", 1, 2'b00, 2'b00, 2'b00);
    trigger = 1'b1;
    run_expect("w0.none", 3, 2'b00, 2'b00, 2'b00);

    // retrigger at cycle 10: ch0 ignores, ch1 restarts
    trigger = 1'b0;
    set_ch(0, 0, 20, 0, 1);
    set_ch(1, 0, 20, 0, 1);
    cfg_retrig = {RETRIG_RESTART, RETRIG_IGNORE};
    run_expect("retrig.pre", 1, 2'b00, 2'b00, 2'b00);
    trigger = 1'b1;
    run_expect("retrig.a", 9, 2'b11, 2'b11, 2'b00);
    trigger = 1'b0;
    run_expect("retrig.b", 1, 2'b11, 2'b11, 2'b00);
    trigger = 1'b1;
    run_expect("retrig.c", 10, 2'b11, 2'b11, 2'b00);
    run_expect("retrig.ch0done", 1, 2'b10, 2'b10, 2'b01);
    run_expect("retrig.ch1only", 9, 2'b10, 2'b10, 2'b00);
    run_expect("retrig.ch1done", 1, 2'b00, 2'b00, 2'b10);
    run_expect("retrig.after", 1, 2'b00, 2'b00, 2'b00);

    // abort beats a simultaneous edge; held trigger gives no new edge
    trigger    = 1'b0;
    cfg_retrig = {RETRIG_IGNORE, RETRIG_IGNORE};
    run_expect("abort.pre", 1, 2'b00, 2'b00, 2'b00);
    trigger = 1'b1;
    abort   = 1'b1;
    run_expect("abort.simul", 1, 2'b00, 2'b00, 2'b00);
    abort = 1'b0;
    run_expect("abort.held", 3, 2'b00, 2'b00, 2'b00);
    trigger = 1'b0;
    set_ch(0, 0, 10, 20, 3);
    set_ch(1, 0, 0, 0, 1);
    run_expect("abort2.pre", 1, 2'b00, 2'b00, 2'b00);
    trigger = 1'b1;
    run_expect("abort2.run", 7, 2'b01, 2'b01, 2'b00);
    abort = 1'b1;
    run_expect("abort2.hit", 1, 2'b00, 2'b00, 2'b00);
    abort = 1'b0;
    run_expect("abort2.held", 5, 2'b00, 2'b00, 2'b00);

    // async reset mid-burst
    trigger = 1'b0;
    run_expect("rst.pre", 1, 2'b00, 2'b00, 2'b00);
    trigger = 1'b1;
    run_expect("rst.run", 5, 2'b01, 2'b01, 2'b00);
    #1;
    rst     = 1'b1;
    trigger = 1'b0;
    #1;
    check_all("rst.async", 2'b00, 2'b00, 2'b00);
    run_expect("rst.hold", 2, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    run_expect("rst.after", 40, 2'b00, 2'b00, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_gen_burst.md
Name: pulse_gen_burst

Overview:
- Parametrised multi-channel successor to the single-shot pulse generator.
- On a rising edge of a shared trigger, each channel waits a programmable delay, then emits a burst of programmable-width pulses at a programmable period.
- Per-channel retrigger mode and a synchronous abort are provided.
- Sits between the trigger/sync logic and DAC/gate outputs of the function generator; configuration comes from the register block.

Parameters:
- NUM_CH, 2, number of independent channels (1..8).
- CNT_W, 32, width of every timing counter and config field.
- DEFAULT_WIDTH, 128, reset value of every channel's width shadow register.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- trigger  in  1  shared trigger level; only rising edges are used
- abort  in  1  synchronous abort of all channels
- cfg_delay  in  NUM_CH*CNT_W  per-channel cycles from trigger edge to first pulse; channel i uses bits [i*CNT_W +: CNT_W]
- cfg_width  in  NUM_CH*CNT_W  per-channel high time, in cycles
- cfg_period  in  NUM_CH*CNT_W  per-channel pulse-start-to-pulse-start spacing, in cycles
- cfg_count  in  NUM_CH*CNT_W  per-channel pulses per burst
- cfg_retrig  in  NUM_CH  per-channel mode: 0 = ignore trigger while busy, 1 = restart
- pulse  out  NUM_CH  registered pulse outputs
- busy  out  NUM_CH  channel in DELAY/HIGH/LOW
- done  out  NUM_CH  one-cycle strobe when a burst completes normally

Behaviour:
- Reset (async): pulse=0, busy=0, done=0, last_trigger=0, all counters 0, state IDLE.
- Edge detect: trig_edge = trigger & ~last_trigger; last_trigger is registered every cycle. trigger is already synchronous to clk.
- Acceptance: a channel accepts trig_edge when in IDLE, or when busy with cfg_retrig=1.
  - On acceptance, delay/width/period/count are latched into shadow registers.
  - Config changes mid-burst have no effect.
- Field clamps, applied at latch time:
  - width=0: trigger not accepted, channel stays IDLE, no busy.
  - count=0 is treated as 1.
  - period<=width is clamped to width+1 (at least one low cycle between pulses).
- Per-channel FSM:
  - IDLE, accept, delay=0 -> HIGH. pulse=1 from the edge that sees trig_edge (zero added latency).
  - IDLE, accept, delay=D>0 -> DELAY for D cycles; pulse rises D cycles after the delay=0 case.
  - HIGH lasts exactly width cycles. Then: if pulses remaining -> LOW; else -> IDLE with done=1 for one cycle.
  - LOW lasts period-width cycles -> HIGH.
- busy=1 in DELAY/HIGH/LOW. It rises on the same edge as leaving IDLE and falls on the same edge done pulses.
- Retrigger:
  - Mode 0: edges are ignored while busy.
  - Mode 1: the burst restarts as if from IDLE (new latch, counters reloaded). If delay>0, pulse drops on the next edge. No done strobe for the truncated burst.
- abort: all channels -> IDLE next edge, with pulse=0, busy=0, done=0. abort has priority over a simultaneous trig_edge.
- Counters: down-counters of CNT_W bits with no wrap. Max value 2^CNT_W-1 is legal in every field.
- Channels are fully independent apart from the shared trigger/abort; all outputs are registered.

Decomposition:
- Shared package pulse_gen_pkg holds:
  - state encoding (ST_IDLE, ST_DELAY, ST_HIGH, ST_LOW)
  - retrigger mode constants (RETRIG_IGNORE=0, RETRIG_RESTART=1)
  - the default CNT_W
- Sub-module pulse_gen_chan: one channel FSM plus shadow registers and counters, with a trig_edge input.
- The top module does edge detection, config unpacking, and a generate loop over NUM_CH.

Test Plan:
- Reset mid-burst: ch0 width=10 count=3 running; assert rst at cycle 5 -> pulse/busy go 0 immediately (async), stay IDLE after release, no done.
- Single pulse: ch0 delay=0 width=128 count=1; trigger rises -> pulse high for exactly 128 cycles starting the edge that sees trigger, done one cycle at the fall, busy 128 cycles.
- Burst with delay: delay=5 width=3 period=8 count=4 -> first rise 5 cycles after the edge. Pattern 3 high / 5 low x4. Last pulse followed by done; busy total 5+8*3+3=32 cycles.
- Clamps: width=4 period=2 count=0 -> one pulse of 4 cycles. Then count=2 with the same width/period -> 4 high, 1 low, 4 high. width=0 -> no pulse, no busy.
- Retrigger: ch0 mode 0, ch1 mode 1, both width=20 count=1; second edge at cycle 10 -> ch0 ends at cycle 20 with done; ch1 stays high until cycle 30, done once.
- Abort/simultaneity: abort and trigger edge on the same cycle -> no pulse. Abort at cycle 7 of a burst -> pulse=0 and busy=0 next edge, no done; trigger held high with no new edge -> nothing.
